// File: rtl/tiny1_mmio_hub.sv
// rtl/tiny1_mmio_hub.sv - mmap hub: NCH buffered byte-UART channels, GPIO register, level IRQ
module tiny1_mmio_hub #(
  parameter int NCH      = 2,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int GPIO_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [10:0]       addr,
  input  logic [15:0]       wdata,
  input  logic              wr,
  input  logic              rd,
  output logic [15:0]       rdata,
  input  logic [8*NCH-1:0]  uart_din,
  input  logic [NCH-1:0]    uart_valid,
  input  logic [NCH-1:0]    uart_ready,
  output logic [NCH-1:0]    uart_rd,
  output logic [NCH-1:0]    uart_wr,
  output logic [8*NCH-1:0]  uart_out,
  output logic [GPIO_W-1:0] gpio,
  output logic              irq
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_RXDATA = 3'd1;
  localparam logic [2:0] OFF_TXDATA = 3'd2;
  localparam logic [2:0] OFF_IRQEN  = 3'd3;
  localparam logic [2:0] OFF_COUNT  = 3'd4;

  typedef enum logic {RX_IDLE, RX_HOLD} rx_state_t;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;

  logic [2:0]     off;
  logic           rd_acc;
  logic           wr_acc;
  logic           gpio_hit;
  logic           pend_hit;
  logic [15:0]    rd_val;
  logic [15:0]    ch_val [NCH];
  logic [NCH-1:0] pending;
  logic           unused_bits;

  assign off         = addr[3:1];
  assign rd_acc      = sel & rd;
  assign wr_acc      = sel & wr;
  assign gpio_hit    = (addr[10:1] == 10'h3F8);
  assign pend_hit    = (addr[10:1] == 10'h3F9);
  assign unused_bits = ^{addr[0], wdata[15:8]};

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      logic [7:0]   rx_mem [RX_DEPTH];
      logic [7:0]   tx_mem [TX_DEPTH];
      logic [RAW:0] rx_wp, rx_rp, rx_lvl;
      logic [TAW:0] tx_wp, tx_rp, tx_lvl;
      logic         hit, rx_empty, rx_full, tx_fifo_empty, tx_full;
      logic         rx_take, rx_push, rx_pop, tx_push, tx_pop, ovf_clr;
      logic         rx_ovf, tx_empty, rd_pulse, wr_pulse;
      logic [1:0]   irq_en;
      logic [7:0]   out_byte;
      rx_state_t    rx_st;
      tx_state_t    tx_st;

      assign hit           = (addr[10:4] == 7'(c));
      assign rx_lvl        = rx_wp - rx_rp;
      assign tx_lvl        = tx_wp - tx_rp;
      assign rx_empty      = (rx_wp == rx_rp);
      assign tx_fifo_empty = (tx_wp == tx_rp);
      assign rx_full       = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
      assign tx_full       = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
      assign tx_empty      = tx_fifo_empty && (tx_st == TX_IDLE);

      assign rx_take = (rx_st == RX_IDLE) && uart_valid[c];
      assign rx_push = rx_take && !rx_full;
      assign rx_pop  = rd_acc && hit && (off == OFF_RXDATA) && !rx_empty;
      assign tx_push = wr_acc && hit && (off == OFF_TXDATA) && !tx_full;
      assign tx_pop  = (tx_st == TX_IDLE) && !tx_fifo_empty && uart_ready[c];
      assign ovf_clr = wr_acc && hit && (off == OFF_STATUS) && wdata[2];

      assign pending[c]        = (!rx_empty && irq_en[0]) || (tx_empty && irq_en[1]);
      assign uart_rd[c]        = rd_pulse;
      assign uart_wr[c]        = wr_pulse;
      assign uart_out[8*c +: 8] = out_byte;

      assign ch_val[c] = (off == OFF_STATUS) ? {12'd0, tx_empty, rx_ovf, !tx_full, !rx_empty} :
                         (off == OFF_RXDATA) ? (rx_empty ? 16'd0 : {8'd0, rx_mem[rx_rp[RAW-1:0]]}) :
                         (off == OFF_IRQEN)  ? {14'd0, irq_en} :
                         (off == OFF_COUNT)  ? {8'(rx_lvl), 8'(tx_lvl)} : 16'd0;

      // FIFO storage; contents need no reset because the pointers define validity
      always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= uart_din[8*c +: 8];
        if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= wdata[7:0];
      end

      // pointers, flags and the RX/TX handshake FSMs with registered pulse outputs
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rx_wp    <= '0;
          rx_rp    <= '0;
          tx_wp    <= '0;
          tx_rp    <= '0;
          rx_ovf   <= 1'b0;
          irq_en   <= 2'b00;
          rd_pulse <= 1'b0;
          wr_pulse <= 1'b0;
          out_byte <= 8'd0;
          rx_st    <= RX_IDLE;
          tx_st    <= TX_IDLE;
        end else begin
          if (rx_push) rx_wp <= rx_wp + 1'b1;
          if (rx_pop)  rx_rp <= rx_rp + 1'b1;
          if (tx_push) tx_wp <= tx_wp + 1'b1;
          if (tx_pop)  tx_rp <= tx_rp + 1'b1;
          if (wr_acc && hit && (off == OFF_IRQEN)) irq_en <= wdata[1:0];
          if (ovf_clr) rx_ovf <= 1'b0;
          if (rx_take && rx_full) rx_ovf <= 1'b1;

          case (rx_st)
            RX_IDLE: begin
              rd_pulse <= uart_valid[c];
              if (uart_valid[c]) rx_st <= RX_HOLD;
            end
            default: begin
              rd_pulse <= 1'b0;
              rx_st    <= RX_IDLE;
            end
          endcase

          case (tx_st)
            TX_IDLE: begin
              wr_pulse <= tx_pop;
              if (tx_pop) begin
                out_byte <= tx_mem[tx_rp[TAW-1:0]];
                tx_st    <= TX_WAIT;
              end
            end
            default: begin
              wr_pulse <= 1'b0;
              tx_st    <= TX_IDLE;
            end
          endcase
        end
      end
    end
  endgenerate

  // read mux: channel registers, then the two global registers
  always_comb begin
    rd_val = 16'd0;
    for (int i = 0; i < NCH; i++) begin
      if (addr[10:4] == 7'(i)) rd_val = ch_val[i];
    end
    if (gpio_hit)      rd_val = 16'(gpio);
    else if (pend_hit) rd_val = 16'(pending);
  end

  // registered read data, GPIO register and interrupt line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= 16'd0;
      gpio  <= '0;
      irq   <= 1'b0;
    end else begin
      if (rd_acc) rdata <= rd_val;
      if (wr_acc && gpio_hit) gpio <= wdata[GPIO_W-1:0];
      irq <= |pending;
    end
  end
endmodule

// File: doc/tiny1_mmio_hub.md
Name: tiny1_mmio_hub

Overview:
- Parametrised memory-mapped I/O hub for the tiny1 SoC.
- Sits between the core's mmap window (address bit 15 set) and NCH byte-UART channels plus one GPIO output register.
- Per channel it adds RX and TX byte FIFOs, status flags, sticky overflow and a maskable level interrupt.
- Replaces the single-channel, unbuffered UART decode in tiny1_cpu.

Parameters:
NCH, 2, number of UART channels (1..8)
RX_DEPTH, 16, RX FIFO depth in bytes, power of 2, >=2
TX_DEPTH, 16, TX FIFO depth in bytes, power of 2, >=2
GPIO_W, 8, width of GPIO output register (<=16)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
sel  in  1  mmap access (core address bit 15)
addr  in  11  mmap byte address, bit 0 ignored
wdata  in  16  write data from core
wr  in  1  write strobe, one cycle
rd  in  1  read strobe, one cycle
rdata  out  16  registered read data
uart_din  in  8*NCH  RX byte per channel, channel c at bits [8c+7:8c]
uart_valid  in  NCH  RX byte available
uart_ready  in  NCH  transmitter idle
uart_rd  out  NCH  RX consume pulse
uart_wr  out  NCH  TX send pulse
uart_out  out  8*NCH  TX byte per channel
gpio  out  GPIO_W  GPIO register
irq  out  1  interrupt request, level

Behaviour:
- Reset (rst=0, async): FIFOs empty; flags 0; IRQ_EN 0; gpio 0; rdata 0; irq 0; uart_rd 0; uart_wr 0; uart_out 0; both per-channel FSMs in IDLE.
- Decode: an access occurs only when sel=1.
  - Channel c: addr[10:4]==c with c<NCH; offset addr[3:0].
  - Global registers: addr 0x7F0 and 0x7F2.
  - Anything else reads 0; writes to it are ignored.
- Channel registers:
  - 0x0 STATUS (R/W1C)
    - bit0 rx_nonempty
    - bit1 tx_notfull
    - bit2 rx_overflow, sticky; writing 1 clears it
    - bit3 tx_empty, meaning TX FIFO empty and TX FSM IDLE
  - 0x2 RXDATA (R): {8'b0, head byte}. A read pops the FIFO in the rd cycle. Read when empty returns 0, no pop.
  - 0x4 TXDATA (W): pushes wdata[7:0]. Ignored when the FIFO is full.
  - 0x6 IRQ_EN (R/W): bit0 enables rx_nonempty interrupt; bit1 enables tx_empty interrupt.
  - 0x8 COUNT (R): {RX level in [15:8], TX level in [7:0]}.
- Global registers:
  - 0x7F0 GPIO (R/W): gpio <= wdata[GPIO_W-1:0].
  - 0x7F2 IRQ_PENDING (R): bit c = channel c pending.
- Read latency: rdata is updated on the clk edge following rd && sel and holds until the next read. Values are sampled in the rd cycle, before the pop.
- RX FSM per channel, states IDLE and HOLD:
  - IDLE with uart_valid=1: assert uart_rd for 1 cycle. If the FIFO is not full, push uart_din; if full, drop the byte and set rx_overflow. Go to HOLD.
  - HOLD: ignore uart_valid for 1 cycle, then return to IDLE. This gives at most one consume every 2 cycles, so a stale valid never double-reads.
- TX FSM per channel, states IDLE and WAIT:
  - IDLE with TX FIFO nonempty and uart_ready=1: uart_out <= head, uart_wr=1 for 1 cycle, pop, go to WAIT.
  - WAIT: 1 cycle to let the UART raise busy, then return to IDLE.
  - uart_out holds its last value.
- Simultaneous push and pop on one FIFO in the same cycle: both happen and the level is unchanged.
  - Pop on an empty FIFO is a no-op.
  - Push on a full FIFO does nothing, except the RX overflow rule above.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full is when the MSBs differ and the low bits are equal.
- Interrupts:
  - pending[c] = (rx_nonempty & en0) | (tx_empty & en1).
  - irq <= |pending, registered, so 1 cycle latency.
- Reset asserted mid-transfer: all state clears immediately and any in-flight uart_wr or uart_rd pulse drops.

Test Plan:
- Reset, then read STATUS ch0 -> rdata=0x000A (tx_notfull, tx_empty); gpio=0; irq=0.
- Write 0x41, 0x42 to TXDATA ch1 with uart_ready=1 -> uart_wr pulses once per byte with uart_out 0x41 then 0x42, pulses at least 2 cycles apart; hold uart_ready=0 -> no pulse.
- Drive uart_valid=1 continuously with uart_din=0x55 on ch0 -> uart_rd pulses every 2 cycles; after 16 pulses COUNT[15:8]=16; the 17th pulse sets STATUS bit2; reading RXDATA 16 times returns 0x0055 each time, then 0x0000.
- Write STATUS ch0 = 0x0004 -> overflow clears; the other bits are unchanged.
- Set IRQ_EN ch0=1, push one RX byte -> irq=1 one cycle after the push; IRQ_PENDING=0x0001; pop RXDATA -> irq=0 the cycle after.
- Write GPIO 0x00A5 -> gpio=0xA5, readback 0x00A5; access 0x7F4 -> rdata 0, no side effects; assert rst mid-TX -> uart_wr=0, FIFOs empty.
